// File: rtl/ALU_def.sv
// Shared ALU definitions: the ALU operation select plus the multiply sequencer's
// state type and operand width.
package ALU_def;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLL  = 3'd5,
    ALU_SRL  = 3'd6,
    ALU_PASS = 3'd7
  } ALU_CTRL;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } MUL_SEQ_STATE;

  localparam int MUL_SEQ_BITS = 8;

endpackage

// File: rtl/Alu.sv
// Combinational ALU datapath shared by the execute stage and the multiply sequencer.
// Shift operations use the low log2(WIDTH) bits of i_b as the shift amount.
module Alu
  import ALU_def::*;
#(
  parameter int WIDTH = MUL_SEQ_BITS
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  ALU_CTRL          i_ctrl,
  output logic [WIDTH-1:0] o_y,
  output logic             o_cout,
  output logic             o_zero
);

  localparam int SHW = $clog2(WIDTH);

  // For SUB, o_cout reports the borrow out of the top bit.
  always_comb begin
    o_y    = '0;
    o_cout = 1'b0;
    case (i_ctrl)
      ALU_ADD:  {o_cout, o_y} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
      ALU_SUB:  {o_cout, o_y} = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, i_cin};
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SLL:  o_y = i_a << i_b[SHW-1:0];
      ALU_SRL:  o_y = i_a >> i_b[SHW-1:0];
      ALU_PASS: o_y = i_a;
      default:  o_y = '0;
    endcase
  end

  assign o_zero = (o_y == '0);

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that time-shares the ALU: one ADD and one SRL per multiplier bit.
// Optional ALU_MUL_SEQ_SKIP_ZERO_EN skips the ADD step for zero multiplier bits.
module alu_mul_seq
  import ALU_def::*;
#(
  parameter int WIDTH = MUL_SEQ_BITS,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output ALU_CTRL          alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_zero
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  MUL_SEQ_STATE     r_state;
  MUL_SEQ_STATE     w_nextState;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_lastBit;
  logic             w_unused;

  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastBit = (r_cnt == LAST_BIT);
  assign w_unused  = alu_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
`ifdef ALU_MUL_SEQ_SKIP_ZERO_EN
          w_nextState = op_b[0] ? ADD : SHIFT;
`else
          w_nextState = ADD;
`endif
        end else begin
          w_nextState = IDLE;
        end
      end
      ADD: w_nextState = SHIFT;
      SHIFT: begin
        if (w_lastBit) begin
          w_nextState = DONE;
        end else begin
          // r_lo[1] is the multiplier bit that becomes r_lo[0] after this shift.
`ifdef ALU_MUL_SEQ_SKIP_ZERO_EN
          w_nextState = r_lo[1] ? ADD : SHIFT;
`else
          w_nextState = ADD;
`endif
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    alu_ctrl = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    case (r_state)
      ADD: begin
        busy  = 1'b1;
        alu_a = r_hi;
        alu_b = r_lo[0] ? r_mcand : '0;
      end
      SHIFT: begin
        busy     = 1'b1;
        alu_ctrl = ALU_SRL;
        alu_a    = r_hi;
        alu_b    = WIDTH'(1);
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign alu_cin = 1'b0;

  // The ADD carry is parked in r_carry and re-enters as hi's MSB during the following shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_hi    <= '0;
            r_lo    <= op_b;
            r_mcand <= op_a;
            r_cnt   <= '0;
            r_carry <= 1'b0;
          end
        end
        ADD: begin
          r_hi    <= alu_out;
          r_carry <= alu_cout;
        end
        SHIFT: begin
          r_hi    <= {r_carry, alu_out[WIDTH-2:0]};
          r_lo    <= {r_hi[0], r_lo[WIDTH-1:1]};
          r_carry <= 1'b0;
          if (!w_lastBit) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_carry <= 1'b0;
      endcase
    end
  end

  assign product_hi = r_hi;
  assign product_lo = r_lo;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq driving the real Alu; results are compared with a plain a*b model
// and latencies with the bit-count rule (honours ALU_MUL_SEQ_SKIP_ZERO_EN when defined).
module tb_alu_mul_seq;
  import ALU_def::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] product_hi;
  logic [7:0] product_lo;
  ALU_CTRL    alu_ctrl;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_cin;
  logic [7:0] alu_out;
  logic       alu_cout;
  logic       alu_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product_hi(product_hi), .product_lo(product_lo),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero)
  );

  Alu #(.WIDTH(8)) alu (
    .i_a(alu_a), .i_b(alu_b), .i_cin(alu_cin), .i_ctrl(alu_ctrl),
    .o_y(alu_out), .o_cout(alu_cout), .o_zero(alu_zero)
  );

  // Edges from the start edge to the first sample showing done.
  function automatic int expEdges(input logic [7:0] b);
`ifdef ALU_MUL_SEQ_SKIP_ZERO_EN
    return 8 + $countones(b);
`else
    return 16;
`endif
  endfunction

  function automatic logic [31:0] expProduct(input logic [7:0] a, input logic [7:0] b);
    return 32'(a) * 32'(b);
  endfunction

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit holdStart);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    stepClock();
    if (!holdStart) start = 1'b0;
  endtask

  task automatic waitDone(output int edges, output int busyCycles);
    edges      = 0;
    busyCycles = 0;
    while (done !== 1'b1 && edges < 60) begin
      if (busy === 1'b1) busyCycles++;
      stepClock();
      edges++;
    end
    if (done !== 1'b1) checkOutput("done_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic runAndCheck(input string tag, input logic [7:0] a, input logic [7:0] b);
    int e;
    int bc;
    applyStimulus(a, b, 1'b0);
    waitDone(e, bc);
    checkOutput({tag, "_latency"}, e, expEdges(b));
    checkOutput({tag, "_busy"}, bc, expEdges(b));
    checkOutput({tag, "_product"}, {16'b0, product_hi, product_lo}, expProduct(a, b));
    stepClock();
    checkOutput({tag, "_donePulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int e;
    int bc;
    logic [7:0] ra;
    logic [7:0] rb;

    reset = 1'b1;
    start = 1'b0;
    op_a  = 8'h00;
    op_b  = 8'h00;
    stepClock();
    stepClock();
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_product", {16'b0, product_hi, product_lo}, 32'd0);
    checkOutput("idle_alu_ctrl", {29'b0, alu_ctrl}, {29'b0, ALU_ADD});
    checkOutput("idle_alu_a", {24'b0, alu_a}, 32'd0);
    checkOutput("alu_cin", {31'b0, alu_cin}, 32'd0);
    reset = 1'b0;
    stepClock();

    runAndCheck("3x5", 8'd3, 8'd5);
    runAndCheck("255x255", 8'hFF, 8'hFF);
    runAndCheck("80x02", 8'h80, 8'h02);
    runAndCheck("07x00", 8'h07, 8'h00);

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      runAndCheck($sformatf("rand%0d", i), ra, rb);
    end

    // A start pulse while busy must be ignored.
    applyStimulus(8'd2, 8'd2, 1'b0);
    repeat (3) stepClock();
    op_a  = 8'd9;
    op_b  = 8'd9;
    start = 1'b1;
    stepClock();
    start = 1'b0;
    waitDone(e, bc);
    checkOutput("ignore_product", {16'b0, product_hi, product_lo}, expProduct(8'd2, 8'd2));
    for (int i = 0; i < 5; i++) begin
      stepClock();
      checkOutput($sformatf("hold%0d_product", i), {16'b0, product_hi, product_lo}, expProduct(8'd2, 8'd2));
      checkOutput($sformatf("hold%0d_busy", i), {31'b0, busy}, 32'd0);
    end

    // Reset mid-operation discards the partial product.
    applyStimulus(8'd200, 8'd100, 1'b0);
    repeat (4) stepClock();
    reset = 1'b1;
    stepClock();
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    checkOutput("abort_product", {16'b0, product_hi, product_lo}, 32'd0);
    reset = 1'b0;
    stepClock();
    runAndCheck("200x100", 8'd200, 8'd100);

    // Back-to-back: start held high, a new operation begins from DONE.
    applyStimulus(8'd11, 8'd13, 1'b1);
    waitDone(e, bc);
    checkOutput("b2b0_latency", e, expEdges(8'd13));
    checkOutput("b2b0_product", {16'b0, product_hi, product_lo}, expProduct(8'd11, 8'd13));
    checkOutput("b2b0_busy_in_done", {31'b0, busy}, 32'd0);
    for (int i = 1; i < 3; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op_a = ra;
      op_b = rb;
      stepClock();
      waitDone(e, bc);
      checkOutput($sformatf("b2b%0d_period", i), e + 1, expEdges(rb) + 1);
      checkOutput($sformatf("b2b%0d_product", i), {16'b0, product_hi, product_lo}, expProduct(ra, rb));
    end
    start = 1'b0;
    stepClock();
    checkOutput("b2b_end_done", {31'b0, done}, 32'd0);
    checkOutput("b2b_end_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
